ttt_button_conditioner: RTL and testbench

// - Input stage directly upstream of the tic-tac-toe game manager, clocked by the 100 MHz main clock.
// - Synchronises and debounces the five raw push-buttons (S/U/L/D/R).
// - Emits one-cycle press pulses, with auto-repeat on the direction buttons while they are held.
// - Emits a single prioritised command per cycle, so the game manager never sees two moves in one cycle.

---
 rtl/ttt_button_conditioner_pkg.sv | 41 ++++
 rtl/ttt_btn_channel.sv | 122 ++++++++++++
 rtl/ttt_button_conditioner.sv | 46 ++++
 tb/tb_ttt_button_conditioner.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ttt_button_conditioner_pkg.sv
// Shared constants for the tic-tac-toe button front end: button indices,
// command codes, channel FSM encodings and the command priority helper.
package ttt_button_conditioner_pkg;

    localparam int NUM_BTN = 5;

    // Button indices within btn_raw / btn_level / btn_pulse
    localparam int BTN_S = 0;
    localparam int BTN_U = 1;
    localparam int BTN_L = 2;
    localparam int BTN_D = 3;
    localparam int BTN_R = 4;

    // Command codes seen by the game manager
    localparam int CMD_W = 3;
    localparam logic [CMD_W-1:0] CMD_SEL   = 3'd0;
    localparam logic [CMD_W-1:0] CMD_UP    = 3'd1;
    localparam logic [CMD_W-1:0] CMD_LEFT  = 3'd2;
    localparam logic [CMD_W-1:0] CMD_DOWN  = 3'd3;
    localparam logic [CMD_W-1:0] CMD_RIGHT = 3'd4;

    // Per-channel hold tracking
    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_HOLD_DELAY  = 2'd1,
        ST_HOLD_REPEAT = 2'd2
    } ch_state_e;

    // Highest-priority pressed button wins: S > U > L > D > R; 0 when idle
    function automatic logic [CMD_W-1:0] prio_code(input logic [NUM_BTN-1:0] p);
        logic [CMD_W-1:0] c;
        c = CMD_SEL;
        if (p[BTN_S])      c = CMD_SEL;
        else if (p[BTN_U]) c = CMD_UP;
        else if (p[BTN_L]) c = CMD_LEFT;
        else if (p[BTN_D]) c = CMD_DOWN;
        else if (p[BTN_R]) c = CMD_RIGHT;
        return c;
    endfunction

endpackage

// File: rtl/ttt_btn_channel.sv
// One button lane: 2-FF synchroniser, debounce counter and the
// press / auto-repeat FSM producing a single-cycle pulse per event.
//
// state          | meaning
// ST_RELEASED    | debounced level low, waiting for a press
// ST_HOLD_DELAY  | pressed, counting the initial repeat delay
// ST_HOLD_REPEAT | held past the delay, pulsing every RPT_PERIOD cycles
module ttt_btn_channel
    import ttt_button_conditioner_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 1_000_000,
    parameter int unsigned RPT_DELAY  = 50_000_000,
    parameter int unsigned RPT_PERIOD = 15_000_000,
    parameter bit          RPT_EN_BIT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int DB_W  = $clog2(DB_CYCLES + 1);
    localparam int RPT_W = $clog2(RPT_MAX);

    // The first mismatching sample only arms the count; DB_CYCLES further
    // stable samples are needed before the level is accepted.
    localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DB_CYCLES);
    localparam logic [RPT_W-1:0] DELAY_LAST   = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST  = RPT_W'(RPT_PERIOD - 1);
    localparam logic [RPT_W-1:0] RPT_SAT      = {RPT_W{1'b1}};

    logic            sync1_q, sync2_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_inc;
    ch_state_e       state_q;
    logic            pulse_q;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive disagreeing samples, accept after enough
    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST)
                level_d = sync2_q;
            else if (db_cnt_q != {DB_W{1'b1}})
                db_cnt_d = db_cnt_q + 1'b1;
            else
                db_cnt_d = db_cnt_q;
        end
    end

    // Saturating increment so a disabled repeat lane can sit forever
    always_comb begin
        rpt_inc = (rpt_cnt_q == RPT_SAT) ? rpt_cnt_q : rpt_cnt_q + 1'b1;
    end

    // Debounce registers plus the press/repeat FSM; release beats any tick
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            rpt_cnt_q <= '0;
            state_q   <= ST_RELEASED;
            pulse_q   <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
            pulse_q  <= 1'b0;
            if (!level_d) begin
                state_q   <= ST_RELEASED;
                rpt_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_RELEASED: begin
                        pulse_q   <= 1'b1;
                        state_q   <= ST_HOLD_DELAY;
                        rpt_cnt_q <= '0;
                    end
                    ST_HOLD_DELAY: begin
                        if (RPT_EN_BIT && (rpt_cnt_q == DELAY_LAST)) begin
                            pulse_q   <= 1'b1;
                            state_q   <= ST_HOLD_REPEAT;
                            rpt_cnt_q <= '0;
                        end else begin
                            rpt_cnt_q <= rpt_inc;
                        end
                    end
                    ST_HOLD_REPEAT: begin
                        if (rpt_cnt_q == PERIOD_LAST) begin
                            pulse_q   <= 1'b1;
                            rpt_cnt_q <= '0;
                        end else begin
                            rpt_cnt_q <= rpt_inc;
                        end
                    end
                    default: begin
                        state_q   <= ST_RELEASED;
                        rpt_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/ttt_button_conditioner.sv
// Five-button front end for the game manager: one conditioning lane per
// button and a registered priority encoder so only one command per cycle.
module ttt_button_conditioner
    import ttt_button_conditioner_pkg::*;
#(
    parameter int unsigned        DB_CYCLES  = 1_000_000,
    parameter int unsigned        RPT_DELAY  = 50_000_000,
    parameter int unsigned        RPT_PERIOD = 15_000_000,
    parameter logic [NUM_BTN-1:0] RPT_EN     = 5'b11110
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic               cmd_valid,
    output logic [CMD_W-1:0]   cmd_code
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        ttt_btn_channel #(
            .DB_CYCLES  (DB_CYCLES),
            .RPT_DELAY  (RPT_DELAY),
            .RPT_PERIOD (RPT_PERIOD),
            .RPT_EN_BIT (RPT_EN[i])
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .btn_raw_i (btn_raw[i]),
            .level_o   (btn_level[i]),
            .pulse_o   (btn_pulse[i])
        );
    end

    // Register the winning command one cycle after the pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd_code  <= CMD_SEL;
        end else begin
            cmd_valid <= |btn_pulse;
            cmd_code  <= prio_code(btn_pulse);
        end
    end

endmodule

// File: tb/tb_ttt_button_conditioner.sv
// Directed bench for ttt_button_conditioner with short timing parameters
// (DB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=8).
module tb_ttt_button_conditioner;
    import ttt_button_conditioner_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_pulse;
    logic               cmd_valid;
    logic [CMD_W-1:0]   cmd_code;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    ttt_button_conditioner #(
        .DB_CYCLES  (4),
        .RPT_DELAY  (20),
        .RPT_PERIOD (8),
        .RPT_EN     (5'b11110)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Hold button b from iteration 0, release before edge rel_k. Edge k is the
    // k-th edge after the raw change. Press lands on edge 6, repeats at
    // 26, 34, ... while the level is still high; level falls on edge rel_k+6.
    task automatic hold_check(input string tag, input int b, input bit rep,
                              input int rel_k, input int n);
        int         fall;
        int         np;
        int         nexp;
        logic       prev;
        logic       ep;
        logic [4:0] onehot;
        logic [4:0] exp_p;
        logic [4:0] exp_l;
        fall   = rel_k + 6;
        np     = 0;
        nexp   = 0;
        prev   = 1'b0;
        onehot = 5'd1 << b;
        btn_raw = onehot;
        for (int k = 0; k < n; k++) begin
            if (k == rel_k) btn_raw = '0;
            tick();
            ep    = (k == 6) || (rep && k >= 26 && k < fall && ((k - 26) % 8 == 0));
            exp_p = ep ? onehot : 5'd0;
            exp_l = (k >= 6 && k < fall) ? onehot : 5'd0;
            chk({tag, "_pulse"}, 32'(btn_pulse), 32'(exp_p));
            chk({tag, "_level"}, 32'(btn_level), 32'(exp_l));
            chk({tag, "_cmdv"},  32'(cmd_valid), 32'(prev));
            chk({tag, "_code"},  32'(cmd_code),  prev ? 32'(b) : 32'd0);
            if (btn_pulse[b]) np++;
            if (ep) nexp++;
            prev = ep;
        end
        chk({tag, "_npulse"}, 32'(np), 32'(nexp));
    endtask

    initial begin
        logic b_seq [5];
        b_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset state
        rst     = 1'b1;
        btn_raw = '0;
        repeat (3) tick();
        chk("rst_level", 32'(btn_level), 32'd0);
        chk("rst_pulse", 32'(btn_pulse), 32'd0);
        chk("rst_cmdv",  32'(cmd_valid), 32'd0);
        chk("rst_code",  32'(cmd_code),  32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Clean press of UP: pulse at edge 6, command UP at edge 7
        hold_check("clean", BTN_U, 1'b1, 12, 24);

        // Bounce on SELECT never reaches the level
        for (int i = 0; i < 5; i++) begin
            btn_raw[BTN_S] = b_seq[i];
            tick();
            chk("bounce_level", 32'(btn_level), 32'd0);
            chk("bounce_pulse", 32'(btn_pulse), 32'd0);
        end
        btn_raw = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("bounce_tail_level", 32'(btn_level), 32'd0);
            chk("bounce_tail_pulse", 32'(btn_pulse), 32'd0);
            chk("bounce_tail_cmdv",  32'(cmd_valid), 32'd0);
        end
        hold_check("bounce_hold", BTN_S, 1'b0, 10, 20);

        // Auto-repeat on RIGHT; repeat due at edge 66 coincides with release
        hold_check("rpt_r", BTN_R, 1'b1, 60, 80);
        // SELECT never repeats
        hold_check("rpt_s", BTN_S, 1'b0, 60, 80);

        // LEFT and DOWN together: both pulse, only LEFT becomes a command
        btn_raw = 5'b01100;
        for (int k = 0; k < 20; k++) begin
            if (k == 10) btn_raw = '0;
            tick();
            chk("simul_pulse", 32'(btn_pulse), (k == 6) ? 32'h0C : 32'h0);
            chk("simul_level", 32'(btn_level), (k >= 6 && k < 16) ? 32'h0C : 32'h0);
            chk("simul_cmdv",  32'(cmd_valid), (k == 7) ? 32'd1 : 32'd0);
            chk("simul_code",  32'(cmd_code),  (k == 7) ? 32'(CMD_LEFT) : 32'd0);
        end

        // Reset while DOWN is in HOLD_REPEAT, then re-debounce
        btn_raw = 5'b01000;
        for (int k = 0; k < 30; k++) begin
            tick();
            chk("rsthold_pulse", 32'(btn_pulse), (k == 6 || k == 26) ? 32'h08 : 32'h0);
        end
        rst = 1'b1;
        tick();
        chk("rsthold_rst_level", 32'(btn_level), 32'd0);
        chk("rsthold_rst_pulse", 32'(btn_pulse), 32'd0);
        chk("rsthold_rst_cmdv",  32'(cmd_valid), 32'd0);
        chk("rsthold_rst_code",  32'(cmd_code),  32'd0);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("rsthold_re_pulse", 32'(btn_pulse), (k == 6) ? 32'h08 : 32'h0);
            chk("rsthold_re_level", 32'(btn_level), (k >= 6) ? 32'h08 : 32'h0);
            chk("rsthold_re_cmdv",  32'(cmd_valid), (k == 7) ? 32'd1 : 32'd0);
            chk("rsthold_re_code",  32'(cmd_code),  (k == 7) ? 32'(CMD_DOWN) : 32'd0);
        end
        btn_raw = '0;
        for (int k = 0; k < 10; k++) tick();
        chk("rsthold_rel_level", 32'(btn_level), 32'd0);

        // UP released so the level falls on the edge the first repeat is due
        hold_check("race", BTN_U, 1'b1, 20, 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
